// File: rtl/uart_tx_rr_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ valid/ack requesters.
// Captures the granted word, issues it to the Tx core and tracks the frame to completion.
module uart_tx_rr_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic                           UART_Tx_RQST,
    output logic [WORD_LENGTH-1:0]         Tx_DATA,
    input  logic                           UART_Tx_READY_BUSY,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           sched_busy,
    output logic                           frame_done,
    output logic                           timeout_err
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    // Tx status encoding: low = ready, high = busy
    localparam logic TxReady = 1'b0;
    localparam logic TxBusy  = 1'b1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e                 state_q, state_d;
    logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]         grant_q, grant_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   rqst_q, rqst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   terr_q, terr_d;

    logic [WORD_LENGTH-1:0] words [NUM_REQ];
    logic                   pick_found;
    logic [IdW-1:0]         pick_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    // First valid requester strictly after the last grant, wrapping.
    always_comb begin
        int unsigned    idx;
        logic [IdW-1:0] idx_w;
        idx        = 0;
        idx_w      = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx   = (32'(rr_ptr_q) + k) % NUM_REQ;
            idx_w = IdW'(idx);
            if (!pick_found && req_valid[idx_w]) begin
                pick_found = 1'b1;
                pick_idx   = idx_w;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        rqst_d   = rqst_q;
        busy_d   = busy_q;
        ack_d    = '0;
        done_d   = 1'b0;
        terr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && pick_found && (UART_Tx_READY_BUSY == TxReady)) begin
                    data_d          = words[pick_idx];
                    grant_d         = pick_idx;
                    rr_ptr_d        = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    busy_d          = 1'b1;
                    rqst_d          = 1'b1;
                    cnt_d           = '0;
                    state_d         = StIssue;
                end
            end
            StIssue: begin
                if (UART_Tx_READY_BUSY == TxBusy) begin
                    rqst_d  = 1'b0;
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    // Tx never picked the word up; drop it and free the scheduler
                    rqst_d  = 1'b0;
                    terr_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                // Tx_DATA stays put: the core samples it during its START state
                if (UART_Tx_READY_BUSY == TxReady) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= IdW'(NUM_REQ - 1);
            grant_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            rqst_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rqst_q   <= rqst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
        end
    end

    assign req_ack      = ack_q;
    assign UART_Tx_RQST = rqst_q;
    assign Tx_DATA      = data_q;
    assign grant_id     = grant_q;
    assign sched_busy   = busy_q;
    assign frame_done   = done_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_uart_tx_rr_scheduler.sv
// Bench for uart_tx_rr_scheduler: directed scenarios plus randomized round-robin traffic
// against a queue-based reference and a behavioural Tx core model.
module tb_uart_tx_rr_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data  = '0;
    logic [N-1:0]   req_ack;
    logic           UART_Tx_RQST;
    logic [W-1:0]   Tx_DATA;
    logic           tx_rb;
    logic [1:0]     grant_id;
    logic           sched_busy;
    logic           frame_done;
    logic           timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx_rr_scheduler #(
        .NUM_REQ    (N),
        .WORD_LENGTH(W),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ack           (req_ack),
        .UART_Tx_RQST      (UART_Tx_RQST),
        .Tx_DATA           (Tx_DATA),
        .UART_Tx_READY_BUSY(tx_rb),
        .grant_id          (grant_id),
        .sched_busy        (sched_busy),
        .frame_done        (frame_done),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural Tx core: 0 = ready, 1 = busy. Goes busy some cycles after RQST,
    // logs the word it picked up, stays busy for a frame, then returns ready.
    int           tx_st = 0;
    int           tx_cnt_q = 0;
    int           tx_n = 0;
    logic [W-1:0] tx_log [512];
    logic         tx_dead = 1'b0;
    int           tx_lat_cfg = 0;
    int           tx_len_cfg = 0;

    function automatic int rnd_or(input int cfg, input int lo, input int hi);
        return (cfg != 0) ? cfg : int'($urandom_range(hi, lo));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_rb    <= 1'b0;
            tx_st    <= 0;
            tx_cnt_q <= 0;
        end else begin
            case (tx_st)
                0: if (UART_Tx_RQST && !tx_dead) begin
                    tx_st    <= 1;
                    tx_cnt_q <= rnd_or(tx_lat_cfg, 2, 5) - 1;
                end
                1: if (tx_cnt_q <= 1) begin
                    tx_rb              <= 1'b1;
                    tx_st              <= 2;
                    tx_cnt_q           <= rnd_or(tx_len_cfg, 2, 6);
                    tx_log[tx_n % 512] <= Tx_DATA;
                    tx_n               <= tx_n + 1;
                end else begin
                    tx_cnt_q <= tx_cnt_q - 1;
                end
                2: if (tx_cnt_q <= 1) begin
                    tx_rb <= 1'b0;
                    tx_st <= 0;
                end else begin
                    tx_cnt_q <= tx_cnt_q - 1;
                end
                default: tx_st <= 0;
            endcase
        end
    end

    // Continuous invariants
    logic         mon_busy_q = 1'b0;
    logic [W-1:0] mon_data_q = '0;
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
            if (UART_Tx_RQST) check_eq("rqst_needs_busy", sched_busy, 1);
            if (mon_busy_q && sched_busy) check_eq("data_hold", Tx_DATA, mon_data_q);
        end
        mon_busy_q <= sched_busy && !rst;
        mon_data_q <= Tx_DATA;
    end

    task automatic wait_any_ack(input int bound, output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (|req_ack) return;
        end
        cyc = -1;
    endtask

    task automatic wait_end(input int bound, output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (frame_done || timeout_err) return;
        end
        cyc = -1;
    endtask

    // Reference: round-robin over per-requester word queues
    logic [W-1:0] mq [N][$];
    logic [W-1:0] drv_q [N][$];
    int           exp_id[$];
    logic [W-1:0] exp_dat[$];
    logic [W-1:0] exp_all[$];
    int           model_ptr = N - 1;

    function automatic void build_expect(input int ptr);
        int p, pick;
        p = ptr;
        for (int step = 0; step < 64; step++) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && mq[(p + k) % N].size() > 0) pick = (p + k) % N;
            end
            if (pick < 0) break;
            exp_id.push_back(pick);
            exp_dat.push_back(mq[pick].pop_front());
            p = pick;
        end
    endfunction

    task automatic drive_requesters();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = drv_q[i].size() > 0;
            req_data[i*W +: W] = (drv_q[i].size() > 0) ? drv_q[i][0] : '0;
        end
    endtask

    task automatic run_round(input int r);
        int           base, cyc, nwords, len;
        logic [W-1:0] d;
        base = tx_n;
        for (int i = 0; i < N; i++) begin
            len = (r == 0) ? ((i == 2) ? 0 : 2) : int'($urandom_range(5, 0));
            mq[i].delete();
            drv_q[i].delete();
            for (int j = 0; j < len; j++) begin
                d = W'($urandom);
                mq[i].push_back(d);
                drv_q[i].push_back(d);
            end
        end
        exp_id.delete();
        exp_dat.delete();
        build_expect(model_ptr);
        exp_all = exp_dat;
        nwords  = exp_id.size();
        drive_requesters();
        cyc = 0;
        while ((exp_id.size() > 0 || sched_busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    if (exp_id.size() == 0) begin
                        check_eq("rr_extra_ack", req_ack, 0);
                    end else begin
                        check_eq("rr_order", i, exp_id[0]);
                        check_eq("rr_grant_id", grant_id, exp_id[0]);
                        check_eq("rr_data", Tx_DATA, exp_dat[0]);
                        model_ptr = exp_id[0];
                        void'(exp_id.pop_front());
                        void'(exp_dat.pop_front());
                    end
                    if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                end
            end
            drive_requesters();
        end
        check_eq("rr_all_granted", exp_id.size(), 0);
        check_eq("rr_frame_count", tx_n - base, nwords);
        for (int k = 0; k < nwords && k < tx_n - base; k++) begin
            check_eq("rr_line_data", tx_log[(base + k) % 512], exp_all[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int           cyc, cnt;
        logic [N-1:0] acc;
        logic [W-1:0] data_at_done;

        // Reset state
        #1 rst = 1'b1;
        #12;
        check_eq("rst_rqst", UART_Tx_RQST, 0);
        check_eq("rst_data", Tx_DATA, 0);
        check_eq("rst_ack", req_ack, 0);
        check_eq("rst_busy", sched_busy, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_pulses", {frame_done, timeout_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // Single send from requester 2
        tx_lat_cfg = 2;
        tx_len_cfg = 4;
        req_data = {$urandom, $urandom};
        req_data[2*W +: W] = 8'hA5;
        req_valid = 4'b0100;
        wait_any_ack(10, cyc);
        check_eq("t1_ack_latency", cyc, 1);
        check_eq("t1_ack", req_ack, 4'b0100);
        check_eq("t1_grant", grant_id, 2);
        check_eq("t1_data", Tx_DATA, 8'hA5);
        check_eq("t1_rqst", UART_Tx_RQST, 1);
        check_eq("t1_busy", sched_busy, 1);
        req_valid = '0;
        req_data = {$urandom, $urandom};
        cnt = 0;
        data_at_done = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (frame_done) begin
                cnt++;
                data_at_done = Tx_DATA;
            end
        end
        check_eq("t1_done_count", cnt, 1);
        check_eq("t1_data_at_done", data_at_done, 8'hA5);
        check_eq("t1_line_data", tx_log[(tx_n - 1) % 512], 8'hA5);
        check_eq("t1_idle", sched_busy, 0);
        model_ptr  = 2;
        tx_lat_cfg = 0;
        tx_len_cfg = 0;

        // Timeout: Tx never reports busy
        tx_dead   = 1'b1;
        req_valid = 4'b0010;
        wait_any_ack(10, cyc);
        check_eq("t3_ack_latency", cyc, 1);
        check_eq("t3_ack", req_ack, 4'b0010);
        req_valid = '0;
        cnt = 0;
        while (UART_Tx_RQST && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("t3_rqst_cycles", cnt, 64);
        check_eq("t3_timeout_pulse", timeout_err, 1);
        check_eq("t3_busy_clear", sched_busy, 0);
        check_eq("t3_no_done", frame_done, 0);
        @(negedge clk);
        check_eq("t3_pulse_width", timeout_err, 0);
        tx_dead   = 1'b0;
        req_valid = 4'b0111;
        wait_any_ack(10, cyc);
        check_eq("t3_next_latency", cyc, 1);
        check_eq("t3_next_ack", req_ack, 4'b0100);
        req_valid = '0;
        wait_end(100, cyc);
        check_eq("t3_next_done", frame_done, 1);
        model_ptr = 2;

        // Enable gating with requester 0 pending during a frame
        req_valid = 4'b1000;
        wait_any_ack(10, cyc);
        check_eq("t4_ack3", req_ack, 4'b1000);
        req_valid = 4'b0001;
        cnt = 0;
        acc = '0;
        while (UART_Tx_RQST && cnt < 50) begin
            @(negedge clk);
            cnt++;
            acc |= req_ack;
        end
        check_eq("t4_issue_end", UART_Tx_RQST, 0);
        check_eq("t4_in_wait", sched_busy, 1);
        en = 1'b0;
        wait_end(100, cyc);
        acc |= req_ack;
        check_eq("t4_frame_done", frame_done, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc |= req_ack;
        end
        check_eq("t4_no_ack_while_off", acc, 0);
        check_eq("t4_idle", sched_busy, 0);
        en = 1'b1;
        wait_any_ack(10, cyc);
        check_eq("t4_en_latency", cyc, 1);
        check_eq("t4_ack0", req_ack, 4'b0001);
        req_valid = '0;
        wait_end(100, cyc);
        check_eq("t4_done0", frame_done, 1);
        model_ptr = 0;

        // Reset mid-frame
        req_valid = 4'b0010;
        wait_any_ack(10, cyc);
        check_eq("t5_ack1", req_ack, 4'b0010);
        req_valid = '0;
        cnt = 0;
        while (UART_Tx_RQST && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("t5_in_wait", sched_busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_busy", sched_busy, 0);
        check_eq("t5_rst_data", Tx_DATA, 0);
        check_eq("t5_rst_grant", grant_id, 0);
        check_eq("t5_rst_rqst", UART_Tx_RQST, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        req_data = {$urandom, $urandom};
        wait_any_ack(10, cyc);
        check_eq("t5_post_latency", cyc, 1);
        check_eq("t5_post_ack", req_ack, 4'b0001);
        req_valid = '0;
        wait_end(100, cyc);
        check_eq("t5_post_done", frame_done, 1);
        model_ptr = 0;

        // Randomized round-robin traffic; round 0 is the 4'b1011 pattern
        for (int r = 0; r < 5; r++) begin
            run_round(r);
            repeat (3) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
